// File: rtl/periph_bus_master_if.sv
// Peripheral bus master interface: CPU-side request/response and peripheral strobe bus.
// Parameters: ADDR_W (bus address width), DATA_W (data width).
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata : CPU request handshake
//   rsp_valid/rsp_rdata                           : one-cycle completion pulse and read data
//   CS_N/RD_N/WR_N/Addr/bus_wdata/bus_rdata       : active-low peripheral bus
// Modports: master (bus initiator), slave (CPU driver plus peripheral responder).
interface periph_bus_master_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              CS_N;
    logic              RD_N;
    logic              WR_N;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, CS_N, RD_N, WR_N, Addr, bus_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, CS_N, RD_N, WR_N, Addr, bus_wdata
    );
endinterface

// File: rtl/periph_bus_master.sv
// Peripheral bus master: turns a CPU load/store request into a CS_N/RD_N/WR_N strobed
// access with SETUP, WAIT_STATES+1 strobe cycles and a one-cycle response pulse.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus (master)   : request/response handshake and peripheral bus (periph_bus_master_if)
//   Intr_n         : responder interrupt, active low
//   irq_ack        : clears irq_pending
//   irq_pending    : latched interrupt
// Optional feature: define PERIPH_BUS_MASTER_IRQ_LATCH_EN to synchronize and latch Intr_n;
// otherwise Intr_n/irq_ack are ignored and irq_pending is 0.
// All bus pins, rsp_valid and rsp_rdata come from flops decoded from the current state, so
// the pins trail the FSM state by one cycle; req_ready is the only combinational output.
module periph_bus_master #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    periph_bus_master_if.master bus,
    input  logic                Intr_n,
    input  logic                irq_ack,
    output logic                irq_pending
);

    localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               cs_n_q, cs_n_d;
    logic               rd_n_q, rd_n_d;
    logic               wr_n_q, wr_n_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               req_ready_c;

    // Ready is forced low during reset without waiting for a clock edge.
    assign req_ready_c = (state_q == IDLE) && !reset;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cs_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_c) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cs_n_d  = 1'b0;
                cnt_d   = CNT_W'(WAIT_STATES);
                state_d = STROBE;
            end
            STROBE: begin
                cs_n_d = 1'b0;
                rd_n_d = we_q;
                wr_n_d = !we_q;
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // The pins still show the last strobe cycle here, so read data is valid now.
                rsp_valid_d = 1'b1;
                if (!we_q) begin
                    rdata_d = bus.bus_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.CS_N      = cs_n_q;
    assign bus.RD_N      = rd_n_q;
    assign bus.WR_N      = wr_n_q;
    assign bus.Addr      = addr_q;
    assign bus.bus_wdata = wdata_q;

`ifdef PERIPH_BUS_MASTER_IRQ_LATCH_EN
    logic intr_s1_q, intr_s2_q, intr_prev_q, irq_pending_q;
    logic intr_fall_c;

    assign intr_fall_c = intr_prev_q && !intr_s2_q;

    // Two-flop synchronizer, edge detect and sticky pending bit (set beats ack).
    always_ff @(posedge clk) begin
        if (reset) begin
            intr_s1_q     <= 1'b1;
            intr_s2_q     <= 1'b1;
            intr_prev_q   <= 1'b1;
            irq_pending_q <= 1'b0;
        end else begin
            intr_s1_q   <= Intr_n;
            intr_s2_q   <= intr_s1_q;
            intr_prev_q <= intr_s2_q;
            if (intr_fall_c) begin
                irq_pending_q <= 1'b1;
            end else if (irq_ack) begin
                irq_pending_q <= 1'b0;
            end
        end
    end

    assign irq_pending = irq_pending_q;
`else
    logic unused_irq;
    assign unused_irq  = Intr_n ^ irq_ack;
    assign irq_pending = 1'b0;
`endif

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
Bus initiator that converts a CPU-side load/store request into a peripheral-bus access on active-low CS_N/RD_N/WR_N strobes with a 12-bit Addr. It is the initiator end for memory-mapped responders such as the timer/counter (Compare 0x000, Counter 0x100, Status 0x200).
- Owns setup/strobe timing, captures read data and returns a one-cycle response pulse.
- Optionally latches the peripheral's active-low interrupt line.

Parameters:
WAIT_STATES, 1, extra strobe cycles beyond the first (0..15); strobe active WAIT_STATES+1 cycles
ADDR_W, 12, peripheral address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  master can accept request (high only in IDLE and not in reset)
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  peripheral address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse: transaction complete
rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads
CS_N  out  1  chip select, active low
RD_N  out  1  read strobe, active low
WR_N  out  1  write strobe, active low
Addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data (to responder DataIn)
bus_rdata  in  DATA_W  bus read data (from responder DataOut)
Intr_n  in  1  responder interrupt, active low
irq_ack  in  1  clears irq_pending (feature only)
irq_pending  out  1  latched interrupt (feature only; tied 0 otherwise)

Behaviour:
- Reset values:
  - CS_N=RD_N=WR_N=1; Addr=0; bus_wdata=0; rsp_valid=0; rsp_rdata=0; irq_pending=0.
  - State=IDLE; wait counter=0; req_ready=0 while reset is high.
- All bus outputs, rsp_valid and rsp_rdata are registered; no combinational path from req_* to bus pins.
- FSM states: IDLE, SETUP, STROBE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch addr/wdata/we into Addr, bus_wdata and a we register; go to SETUP.
- SETUP (1 cycle):
  - CS_N=0, RD_N=WR_N=1; Addr and bus_wdata stable.
  - Go to STROBE and load wait counter with WAIT_STATES.
- STROBE (WAIT_STATES+1 cycles):
  - CS_N=0; RD_N=0 if read, WR_N=0 if write; never both low.
  - Counter decrements each cycle; when it is 0, go to RESP.
  - On reads, bus_rdata is sampled on the final STROBE edge into rsp_rdata.
- RESP (1 cycle):
  - CS_N=RD_N=WR_N=1; rsp_valid=1; return to IDLE.
  - No response backpressure.
- Write transactions leave rsp_rdata unchanged.
- Addr and bus_wdata hold their values after a transaction until the next accept.
- Timing: accept edge to rsp_valid high is WAIT_STATES+3 cycles. With req_valid held high, successive accepts are exactly WAIT_STATES+4 cycles apart.
- Request fields are ignored outside the accept handshake.
- WAIT_STATES=0 gives a single-cycle strobe.
- Wait counter width is max(1, clog2(WAIT_STATES+1)).
- Reset mid-transaction (any state):
  - Strobes and CS_N are high at the next edge; no rsp_valid is issued.
  - The in-flight request is dropped.

Optional Feature:
Macro PERIPH_BUS_MASTER_IRQ_LATCH_EN.
- Defined:
  - Intr_n passes through a 2-flop synchronizer, reset to 1.
  - A falling edge of the synchronized signal sets irq_pending at the following edge.
  - irq_ack clears it; set wins if both occur in the same cycle.
- Undefined: Intr_n and irq_ack are unused; irq_pending is constant 0.

Test Plan:
- Write, WAIT_STATES=1: req addr=0x000, wdata=0x0000_0010, we=1 -> CS_N low 3 cycles, WR_N low 2 cycles starting 1 cycle after CS_N, RD_N stays 1, bus_wdata=0x10, rsp_valid 4 cycles after accept, rsp_rdata unchanged.
- Read: addr=0x100, bus_rdata model=0xDEAD_BEEF -> RD_N low 2 cycles; rsp_rdata=0xDEADBEEF when rsp_valid=1; WR_N stays 1.
- Back-to-back: req_valid held high with two requests -> accepts exactly 5 cycles apart (WAIT_STATES=1); req_ready=0 from SETUP through RESP.
- WAIT_STATES=0 read of addr 0x200 returning 0x1 -> single-cycle RD_N pulse, rsp_valid 3 cycles after accept, rsp_rdata=0x1.
- Reset asserted in second STROBE cycle -> next edge CS_N=RD_N=WR_N=1, rsp_valid never pulses, req_ready=0 during reset and 1 the cycle after release.
- Feature on: Intr_n 1->0 -> irq_pending=1 three edges later; irq_ack=1 -> clears; ack coincident with a new falling edge -> stays 1. Feature off -> irq_pending constant 0.
